mult_div_unit: RTL and testbench

//   Iterative 32-bit multiply/divide unit in the execute stage, alongside the ALU.

---
 rtl/mult_div_unit_if.sv | 28 ++
 rtl/mult_div_unit.sv | 207 ++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Operand, control and result bundle between the execute-stage control and the
// iterative multiply/divide unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide share one accumulator and always
// take WIDTH iterations, followed by one sign-correction/write-back cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    // Two's complement negation helpers for single- and double-width values.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH:0]   acc_q, acc_d;      // {remainder/high product, quotient/low product}
    logic [WIDTH-1:0]   b_q, b_d;          // multiplicand / divisor magnitude
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;  // raw dividend for the divide-by-zero result
    logic [1:0]         op_q, op_d;
    logic               neg_res_q, neg_res_d;  // product / quotient sign
    logic               neg_rem_q, neg_rem_d;  // remainder sign (dividend sign)
    logic               dz_q, dz_d;            // current divide has a zero divisor
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;

    logic               sa_s, sb_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH:0]   sh_s;
    logic [WIDTH:0]     trial_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

    // Next-state, datapath iteration and HI/LO write-back selection.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        b_d        = b_q;
        a_raw_d    = a_raw_q;
        op_d       = op_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        sa_s    = ~bus.op[0] & bus.a[WIDTH-1];
        sb_s    = ~bus.op[0] & bus.b[WIDTH-1];
        mag_a_s = sa_s ? neg_w(bus.a) : bus.a;
        mag_b_s = sb_s ? neg_w(bus.b) : bus.b;
        sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        sh_s    = acc_q << 1;
        trial_s = sh_s[2*WIDTH:WIDTH] - {1'b0, b_q};
        prod_s  = acc_q[2*WIDTH-1:0];
        quo_s   = acc_q[WIDTH-1:0];
        rem_s   = acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d      = bus.op;
                    acc_d     = {{(WIDTH+1){1'b0}}, mag_a_s};
                    b_d       = mag_b_s;
                    a_raw_d   = bus.a;
                    neg_res_d = sa_s ^ sb_s;
                    neg_rem_d = sa_s;
                    dz_d      = (bus.b == {WIDTH{1'b0}});
                    count_d   = {CW{1'b0}};
                    state_d   = ST_RUN;
                end else begin
                    if (bus.hi_we) begin
                        hi_d = bus.wdata;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (bus.lo_we) begin
                        lo_d = bus.wdata;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            ST_RUN: begin
                if (op_q[1]) begin
                    // Restoring divide: keep the shifted remainder if the trial goes negative.
                    if (!trial_s[WIDTH]) begin
                        acc_d = {trial_s, sh_s[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, 1'b1}};
                    end else begin
                        acc_d = sh_s;
                    end
                end else begin
                    // Shift-add multiply: add multiplicand when the current multiplier bit is set.
                    if (acc_q[0]) begin
                        acc_d = {1'b0, sum_s, acc_q[WIDTH-1:1]};
                    end else begin
                        acc_d = {2'b00, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:1]};
                    end
                end
                count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                if (count_q == CW'(WIDTH-1)) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (!op_q[1]) begin
                    if ((op_q == OP_MULT) && neg_res_q) begin
                        prod_s = neg_2w(acc_q[2*WIDTH-1:0]);
                    end else begin
                        prod_s = acc_q[2*WIDTH-1:0];
                    end
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end else if (dz_q) begin
                    hi_d       = a_raw_q;
                    lo_d       = {WIDTH{1'b1}};
                    div_zero_d = 1'b1;
                end else begin
                    if ((op_q == OP_DIV) && neg_res_q) begin
                        quo_s = neg_w(acc_q[WIDTH-1:0]);
                    end else begin
                        quo_s = acc_q[WIDTH-1:0];
                    end
                    if ((op_q == OP_DIV) && neg_rem_q) begin
                        rem_s = neg_w(acc_q[2*WIDTH-1:WIDTH]);
                    end else begin
                        rem_s = acc_q[2*WIDTH-1:WIDTH];
                    end
                    hi_d       = rem_s;
                    lo_d       = quo_s;
                    div_zero_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and architectural register update with async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= {CW{1'b0}};
            acc_q      <= {(2*WIDTH+1){1'b0}};
            b_q        <= {WIDTH{1'b0}};
            a_raw_q    <= {WIDTH{1'b0}};
            op_q       <= 2'b00;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            b_q        <= b_d;
            a_raw_q    <= a_raw_d;
            op_q       <= op_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: table-driven operations through a
// scoreboard queue, plus hand sequences for ignored requests, MTHI/MTLO and
// reset in the middle of an operation.
module tb_mult_div_unit;
    logic clk;
    logic rst_n;

    mult_div_unit_if #(.WIDTH(32)) mdu ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mdu.slave)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    vec_t vecs [12];
    exp_t sb_q [$];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge: present a start for one cycle and queue its expected result.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        exp_t e;
        mdu.start = 1'b1;
        mdu.op    = op;
        mdu.a     = a;
        mdu.b     = b;
        @(posedge clk);
        e.hi = ehi;
        e.lo = elo;
        e.dz = edz;
        sb_q.push_back(e);
        @(negedge clk);
        mdu.start = 1'b0;
        mdu.a     = $urandom();
        mdu.b     = $urandom();
    endtask

    // Wait for done, optionally injecting a start+MTHI mid-run and a start in FINISH.
    task automatic wait_done(input string tag, input int inj_cyc, input bit inj_fin);
        int   n;
        exp_t e;
        n = 0;
        while (1) begin
            if (n == inj_cyc) begin
                mdu.start = 1'b1;
                mdu.op    = 2'b01;
                mdu.a     = 32'd5;
                mdu.b     = 32'd5;
                mdu.hi_we = 1'b1;
                mdu.wdata = 32'h0000_1234;
            end
            if (inj_fin && (n == 32)) begin
                mdu.start = 1'b1;
                mdu.op    = 2'b01;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
            mdu.start = 1'b0;
            mdu.hi_we = 1'b0;
            if (mdu.done === 1'b1) break;
            if (n > 100) break;
        end
        check({tag, " latency"}, 32'(n), 32'd33);
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, " hi"}, mdu.hi, e.hi);
            check({tag, " lo"}, mdu.lo, e.lo);
            check({tag, " div_zero"}, {31'd0, mdu.div_zero}, {31'd0, e.dz});
        end
        check({tag, " busy after done"}, {31'd0, mdu.busy}, 32'd0);
    endtask

    initial begin
        int done_seen;
        // {op, a, b, hi, lo, div_zero}
        vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5]  = '{2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
        vecs[6]  = '{2'b00, 32'd3,         32'd5,         32'd0,         32'd15,        1'b1};
        vecs[7]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[8]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[9]  = '{2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0,         32'd15,        1'b0};
        vecs[10] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[11] = '{2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};

        rst_n     = 1'b0;
        mdu.start = 1'b0;
        mdu.op    = 2'b00;
        mdu.a     = 32'd0;
        mdu.b     = 32'd0;
        mdu.hi_we = 1'b0;
        mdu.lo_we = 1'b0;
        mdu.wdata = 32'd0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, mdu.busy}, 32'd0);
        check("reset done", {31'd0, mdu.done}, 32'd0);
        check("reset div_zero", {31'd0, mdu.div_zero}, 32'd0);
        check("reset hi", mdu.hi, 32'd0);
        check("reset lo", mdu.lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: each op starts in the done cycle of the previous one (back-to-back).
        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);
            wait_done($sformatf("vec%0d", i), -1, 1'b0);
        end

        // Start + MTHI mid-run and start during FINISH are all ignored.
        start_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        wait_done("ignore", 5, 1'b1);

        // MTLO in IDLE, HI untouched.
        mdu.lo_we = 1'b1;
        mdu.wdata = 32'h0000_ABCD;
        @(negedge clk);
        mdu.lo_we = 1'b0;
        check("mtlo lo", mdu.lo, 32'h0000_ABCD);
        check("mtlo hi", mdu.hi, 32'd2);

        // MTHI and MTLO together.
        mdu.hi_we = 1'b1;
        mdu.lo_we = 1'b1;
        mdu.wdata = 32'h5A5A_5A5A;
        @(negedge clk);
        mdu.hi_we = 1'b0;
        mdu.lo_we = 1'b0;
        check("mthilo hi", mdu.hi, 32'h5A5A_5A5A);
        check("mthilo lo", mdu.lo, 32'h5A5A_5A5A);

        // Set div_zero, then reset in the middle of a MULT.
        start_op(2'b11, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1);
        wait_done("dz", -1, 1'b0);
        mdu.start = 1'b1;
        mdu.op    = 2'b00;
        mdu.a     = 32'd3;
        mdu.b     = 32'd7;
        @(negedge clk);
        mdu.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset busy", {31'd0, mdu.busy}, 32'd0);
        check("midreset done", {31'd0, mdu.done}, 32'd0);
        check("midreset div_zero", {31'd0, mdu.div_zero}, 32'd0);
        check("midreset hi", mdu.hi, 32'd0);
        check("midreset lo", mdu.lo, 32'd0);
        #2;
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mdu.done === 1'b1) done_seen++;
        end
        check("no done after reset", 32'(done_seen), 32'd0);
        check("idle after reset", {31'd0, mdu.busy}, 32'd0);
        check("lo held after reset", mdu.lo, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
